// File: rtl/distance_text_pkg.sv
// Shared types and constants for the distance overlay text controller:
// FSM state encoding, ASCII codes, screen layout and the static text template.
package distance_text_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CONVERT,
        ST_WAIT_VB,
        ST_WRITE
    } state_t;

    localparam logic [6:0] SPACE = 7'h20;
    localparam logic [6:0] DASH  = 7'h2D;
    localparam logic [6:0] ZERO  = 7'h30;

    localparam int unsigned DIG_COL = 6;
    localparam int unsigned ROW_CUR = 0;
    localparam int unsigned ROW_MAX = 1;

    // Power-up text for a 16-column by 4-row buffer addressed {row[1:0], col[3:0]}:
    // row 0 "DIST:    0 cm   ", row 1 "MAX:     0 cm   ", rows 2-3 blank.
    function automatic logic [6:0] template_char(input logic [5:0] addr);
        logic [1:0] row;
        logic [3:0] col;
        logic       cur;
        logic [6:0] c;
        row = addr[5:4];
        col = addr[3:0];
        cur = (row == 2'(ROW_CUR));
        c   = SPACE;
        if (cur || row == 2'(ROW_MAX)) begin
            case (col)
                4'd0:              c = cur ? 7'h44 : 7'h4D;  // D / M
                4'd1:              c = cur ? 7'h49 : 7'h41;  // I / A
                4'd2:              c = cur ? 7'h53 : 7'h58;  // S / X
                4'd3:              c = cur ? 7'h54 : 7'h3A;  // T / :
                4'd4:              c = cur ? 7'h3A : SPACE;  // : / space
                4'(DIG_COL + 3):   c = ZERO;                 // units digit
                4'd11:             c = 7'h63;                // c
                4'd12:             c = 7'h6D;                // m
                default:           c = SPACE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/distance_text_ctrl_if.sv
// Bus bundle between the distance source / overlay drawer and the text controller.
//   dist_in/dist_valid/dist_ready : sample handshake
//   clr_max                       : clear stored maximum (pulse)
//   vblnk_in                      : vertical blank from timing chain
//   char_xy/char_code             : character buffer read port (1-cycle latency)
//   busy                          : controller not idle
interface distance_text_ctrl_if #(
    parameter int unsigned DIST_W = 12
);
    logic [DIST_W-1:0] dist_in;
    logic              dist_valid;
    logic              dist_ready;
    logic              clr_max;
    logic              vblnk_in;
    logic [6:0]        char_xy;
    logic [6:0]        char_code;
    logic              busy;

    modport master (
        output dist_in, dist_valid, clr_max, vblnk_in, char_xy,
        input  dist_ready, char_code, busy
    );

    modport slave (
        input  dist_in, dist_valid, clr_max, vblnk_in, char_xy,
        output dist_ready, char_code, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
//   start : load bin (first shift is folded into the load), conversion takes DIST_W cycles
//   bcd   : NDIG packed BCD digits, valid while done is high and held afterwards
//   done  : one-cycle pulse when bcd holds the result
module bin2bcd_seq #(
    parameter int unsigned DIST_W = 12,
    parameter int unsigned NDIG   = 4
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIST_W-1:0]   bin,
    output logic [NDIG*4-1:0]   bcd,
    output logic                done
);
    localparam int unsigned BCD_W = NDIG * 4;
    localparam int unsigned CNT_W = $clog2(DIST_W);

    logic [DIST_W-1:0]       sr;
    logic [CNT_W-1:0]        cnt;
    logic [BCD_W-1:0]        adj_c;
    logic [BCD_W+DIST_W-1:0] sh_c;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // One dabble step: adjust digits >= 5, then shift the whole {bcd, sr} left.
    always_comb begin
        adj_c = add3(bcd);
        sh_c  = {adj_c, sr} << 1;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            // bcd is zero on load, so the first shift needs no adjust
            bcd  <= BCD_W'(bin[DIST_W-1]);
            sr   <= {bin[DIST_W-2:0], 1'b0};
            cnt  <= CNT_W'(DIST_W - 1);
            done <= 1'b0;
        end else if (cnt != '0) begin
            bcd  <= sh_c[BCD_W+DIST_W-1:DIST_W];
            sr   <= sh_c[DIST_W-1:0];
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/distance_text_ctrl.sv
// Distance overlay text controller. Accepts distance samples, converts the
// current sample and the running maximum to BCD, and rewrites the digit cells
// of a 64x7 character buffer only after a vblank rising edge.
//   pclk, rst : pixel clock, synchronous active-high reset
//   bus       : sample handshake, clr_max, vblnk_in, buffer read port, busy
module distance_text_ctrl #(
    parameter int unsigned DIST_W   = 12,
    parameter int unsigned MAX_DIST = 400,
    parameter int unsigned NDIG     = 4
) (
    input  logic                 pclk,
    input  logic                 rst,
    distance_text_ctrl_if.slave  bus
);
    import distance_text_pkg::*;

    localparam int unsigned BCD_W = NDIG * 4;
    localparam int unsigned WR_N  = 2 * NDIG;
    localparam int unsigned WR_W  = $clog2(WR_N);
    localparam int unsigned SEL_W = $clog2(NDIG);
    localparam logic [DIST_W-1:0] MAX_D = DIST_W'(MAX_DIST);

    typedef logic [NDIG-1:0][6:0] txt_t;

    state_t             state;
    logic [5:0]         init_cnt;
    logic [WR_W-1:0]    wr_idx;
    logic               conv_phase;
    logic [DIST_W-1:0]  cur_q;
    logic [DIST_W-1:0]  max_q;
    logic               clr_pend;
    logic               vb_q;
    txt_t               cur_txt;
    txt_t               max_txt;

    logic               handshake_c;
    logic [DIST_W-1:0]  base_c;
    logic [DIST_W-1:0]  max_next_c;
    logic               conv_start_c;
    logic [DIST_W-1:0]  conv_bin_c;
    logic [BCD_W-1:0]   conv_bcd;
    logic               conv_done;

    logic               we_c;
    logic [5:0]         waddr_c;
    logic [6:0]         wdata_c;
    logic [SEL_W-1:0]   sel_c;
    logic [6:0]         mem [64];

    // Column i holds the digit of weight 10^(NDIG-1-i); leading zeros blank, units always shown.
    function automatic txt_t fmt_digits(input logic [BCD_W-1:0] bcd);
        txt_t       t;
        logic       lead;
        logic [3:0] d;
        lead = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = bcd[(NDIG-1-i)*4 +: 4];
            if (lead && d == 4'd0 && i != int'(NDIG) - 1) begin
                t[i] = SPACE;
            end else begin
                lead = 1'b0;
                t[i] = ZERO + 7'(d);
            end
        end
        return t;
    endfunction

    // Handshake and max update; clr (direct or pending) applies before the compare.
    always_comb begin
        handshake_c  = (state == ST_IDLE) && bus.dist_ready && bus.dist_valid;
        base_c       = (bus.clr_max || clr_pend) ? '0 : max_q;
        max_next_c   = (bus.dist_in <= MAX_D && bus.dist_in > base_c) ? bus.dist_in : base_c;
        conv_start_c = handshake_c || (state == ST_CONVERT && !conv_phase && conv_done);
        conv_bin_c   = handshake_c ? bus.dist_in : max_q;
    end

    bin2bcd_seq #(
        .DIST_W (DIST_W),
        .NDIG   (NDIG)
    ) u_bcd (
        .pclk   (pclk),
        .rst    (rst),
        .start  (conv_start_c),
        .bin    (conv_bin_c),
        .bcd    (conv_bcd),
        .done   (conv_done)
    );

    // Controller FSM with registered dist_ready / busy.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state          <= ST_INIT;
            init_cnt       <= '0;
            wr_idx         <= '0;
            conv_phase     <= 1'b0;
            cur_q          <= '0;
            max_q          <= '0;
            clr_pend       <= 1'b0;
            vb_q           <= 1'b0;
            cur_txt        <= {NDIG{SPACE}};
            max_txt        <= {NDIG{SPACE}};
            bus.dist_ready <= 1'b0;
            bus.busy       <= 1'b1;
        end else begin
            vb_q <= bus.vblnk_in;
            if (handshake_c)      clr_pend <= 1'b0;
            else if (bus.clr_max) clr_pend <= 1'b1;

            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 6'd1;
                    if (init_cnt == 6'd63) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // ready rises one cycle after entering IDLE
                    if (!bus.dist_ready) begin
                        bus.dist_ready <= 1'b1;
                    end else if (bus.dist_valid) begin
                        state          <= ST_CONVERT;
                        bus.dist_ready <= 1'b0;
                        bus.busy       <= 1'b1;
                        conv_phase     <= 1'b0;
                        cur_q          <= bus.dist_in;
                        max_q          <= max_next_c;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        if (!conv_phase) begin
                            conv_phase <= 1'b1;
                            cur_txt    <= (cur_q > MAX_D) ? txt_t'({NDIG{DASH}}) : fmt_digits(conv_bcd);
                        end else begin
                            max_txt <= fmt_digits(conv_bcd);
                            state   <= ST_WAIT_VB;
                        end
                    end
                end
                ST_WAIT_VB: begin
                    if (bus.vblnk_in && !vb_q) begin
                        state  <= ST_WRITE;
                        wr_idx <= '0;
                    end
                end
                ST_WRITE: begin
                    wr_idx <= wr_idx + WR_W'(1);
                    if (wr_idx == WR_W'(WR_N - 1)) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Buffer write port: template during INIT, digit cells during WRITE.
    always_comb begin
        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = SPACE;
        sel_c   = '0;
        if (state == ST_INIT) begin
            we_c    = 1'b1;
            waddr_c = init_cnt;
            wdata_c = template_char(init_cnt);
        end else if (state == ST_WRITE) begin
            we_c = 1'b1;
            if (wr_idx < WR_W'(NDIG)) begin
                sel_c   = SEL_W'(wr_idx);
                waddr_c = {2'(ROW_CUR), 4'(DIG_COL) + 4'(sel_c)};
                wdata_c = cur_txt[sel_c];
            end else begin
                sel_c   = SEL_W'(wr_idx - WR_W'(NDIG));
                waddr_c = {2'(ROW_MAX), 4'(DIG_COL) + 4'(sel_c)};
                wdata_c = max_txt[sel_c];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (we_c) mem[waddr_c] <= wdata_c;
    end

    // Synchronous read; same-cycle write to the same cell returns old data.
    always_ff @(posedge pclk) begin
        if (rst)                bus.char_code <= SPACE;
        else if (bus.char_xy[6]) bus.char_code <= SPACE;
        else                    bus.char_code <= mem[bus.char_xy[5:0]];
    end

endmodule

// File: tb/tb_distance_text_ctrl.sv
// Scoreboard bench for distance_text_ctrl: buffer reads push the expected
// character into a queue, a negedge monitor pops and compares char_code.
module tb_distance_text_ctrl;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    distance_text_ctrl_if #(.DIST_W(12)) bus ();

    distance_text_ctrl #(
        .DIST_W   (12),
        .MAX_DIST (400),
        .NDIG     (4)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [6:0] exp;
        logic [6:0] addr;
        int         tag;
    } rd_t;

    rd_t        sb_q[$];
    logic [6:0] exp_mem [64];
    logic       rd_issue = 1'b0;
    logic       rd_vld   = 1'b0;
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         step     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read pipeline marker: char_code is valid one cycle after char_xy.
    always @(posedge pclk) rd_vld <= rd_issue;

    always @(negedge pclk) begin
        if (rd_vld) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                rd_t e;
                e = sb_q.pop_front();
                check($sformatf("rd%0d@%02h", e.tag, e.addr), 32'(bus.char_code), 32'(e.exp));
            end
        end
    end

    task automatic set_row(input int row, input string s);
        for (int c = 0; c < 16; c++) exp_mem[row*16+c] = 7'(s.getc(c));
    endtask

    task automatic set_dig(input int row, input string s);
        for (int i = 0; i < 4; i++) exp_mem[row*16+6+i] = 7'(s.getc(i));
    endtask

    task automatic model_template();
        set_row(0, "DIST:    0 cm   ");
        set_row(1, "MAX:     0 cm   ");
        set_row(2, "                ");
        set_row(3, "                ");
    endtask

    task automatic rd(input int a, input logic [6:0] e, input int tag);
        rd_t r;
        r.exp = e; r.addr = 7'(a); r.tag = tag;
        bus.char_xy = 7'(a);
        rd_issue    = 1'b1;
        sb_q.push_back(r);
        @(posedge pclk); #1;
        rd_issue = 1'b0;
    endtask

    task automatic scan_all(input int tag);
        for (int a = 0; a < 64; a++) rd(a, exp_mem[a], tag);
        rd(7'h40, 7'h20, tag);
        rd(7'h7F, 7'h20, tag);
    endtask

    task automatic scan_digits(input int tag);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) rd(r*16+6+i, exp_mem[r*16+6+i], tag);
    endtask

    // Hold reset 3 cycles, then require dist_ready exactly 65 cycles after release.
    task automatic do_reset();
        int n;
        rst = 1'b1;
        bus.dist_valid = 1'b0;
        bus.clr_max    = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_busy",  32'(bus.busy),       32'd1);
        check("rst_ready", 32'(bus.dist_ready), 32'd0);
        check("rst_code",  32'(bus.char_code),  32'h20);
        rst = 1'b0;
        model_template();
        n = 0;
        while (!bus.dist_ready && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        check("ready_latency", 32'(n), 32'd65);
    endtask

    // Handshake one sample; optionally give a vblank edge and verify the write phase.
    task automatic send(input int v, input bit clr, input bit vb_pulse,
                        input string cur_s, input string max_s);
        step++;
        check($sformatf("ready_pre%0d", step), 32'(bus.dist_ready), 32'd1);
        bus.dist_in    = 12'(v);
        bus.dist_valid = 1'b1;
        bus.clr_max    = clr;
        @(posedge pclk); #1;
        bus.dist_valid = 1'b0;
        bus.clr_max    = 1'b0;
        check($sformatf("busy_hs%0d", step),  32'(bus.busy),       32'd1);
        check($sformatf("ready_hs%0d", step), 32'(bus.dist_ready), 32'd0);
        if (vb_pulse) begin
            repeat (25) @(posedge pclk);
            #1;
            scan_digits(step*10 + 1);        // waiting for vblank: old text
            bus.vblnk_in = 1'b1;
            set_dig(0, cur_s);
            set_dig(1, max_s);
            repeat (2) @(posedge pclk);
            #1;
            bus.vblnk_in = 1'b0;             // falls mid-write; sequence must finish
            repeat (6) @(posedge pclk);
            #1;
            check($sformatf("busy_w8_%0d", step), 32'(bus.busy), 32'd1);
            @(posedge pclk); #1;
            check($sformatf("busy_w9_%0d", step),  32'(bus.busy),       32'd0);
            check($sformatf("ready_w9_%0d", step), 32'(bus.dist_ready), 32'd0);
            @(posedge pclk); #1;
            check($sformatf("ready_w10_%0d", step), 32'(bus.dist_ready), 32'd1);
            scan_digits(step*10 + 2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal;
    end

    initial begin
        bus.dist_in    = '0;
        bus.dist_valid = 1'b0;
        bus.clr_max    = 1'b0;
        bus.vblnk_in   = 1'b0;
        bus.char_xy    = '0;

        do_reset();
        scan_all(1);

        send(123, 1'b0, 1'b1, " 123", " 123");
        send(45,  1'b0, 1'b1, "  45", " 123");
        send(401, 1'b0, 1'b1, "----", " 123");
        send(7,   1'b1, 1'b1, "   7", "   7");

        // clr_max while idle is held pending until the next sample
        bus.clr_max = 1'b1;
        @(posedge pclk); #1;
        bus.clr_max = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        send(5,   1'b0, 1'b1, "   5", "   5");
        send(400, 1'b0, 1'b1, " 400", " 400");
        send(0,   1'b0, 1'b1, "   0", " 400");

        // vblank already high: no edge, so nothing may be written
        bus.vblnk_in = 1'b1;
        @(posedge pclk); #1;
        send(250, 1'b0, 1'b0, "", "");
        repeat (40) @(posedge pclk);
        #1;
        check("vbhigh_busy",  32'(bus.busy),       32'd1);
        check("vbhigh_ready", 32'(bus.dist_ready), 32'd0);
        scan_digits(900);
        do_reset();
        scan_all(901);

        // reset during CONVERT discards the sample
        send(250, 1'b0, 1'b0, "", "");
        repeat (10) @(posedge pclk);
        #1;
        scan_digits(902);
        do_reset();
        scan_digits(903);
        bus.vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        bus.vblnk_in = 1'b1;
        repeat (12) @(posedge pclk);
        #1;
        bus.vblnk_in = 1'b0;
        scan_digits(904);

        repeat (3) @(posedge pclk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
